// File: rtl/axi_bus_arbiter_pkg.sv
// axi_bus_arbiter_pkg: shared encodings for the I/D AXI port arbiter.
package axi_bus_arbiter_pkg;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] BURST_INCR = 2'b01;
  function automatic logic resp_err(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction
endpackage

// File: rtl/axi_arb_grant.sv
// axi_arb_grant: read grant select; round-robin on ties when AXI_ARB_ROUND_ROBIN_EN
// is defined, otherwise fixed D-over-I priority.
module axi_arb_grant
  import axi_bus_arbiter_pkg::*;
(
  input  logic cand_i,
  input  logic cand_d,
  input  logic last_grant,
  output logic grant
);
`ifdef AXI_ARB_ROUND_ROBIN_EN
  assign grant = (cand_i && cand_d) ? !last_grant : (cand_d ? GRANT_D : GRANT_I);
`else
  logic unused_rr;
  assign unused_rr = cand_i ^ last_grant;
  assign grant = cand_d ? GRANT_D : GRANT_I;
`endif
endmodule

// File: rtl/axi_bus_arbiter.sv
// axi_bus_arbiter: shares one AXI4 master port between I (read) and D (read/write);
// tie-break policy selected by AXI_ARB_ROUND_ROBIN_EN.
module axi_bus_arbiter
  import axi_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                i_ar_valid,
  output logic                i_ar_ready,
  input  logic [ADDR_W-1:0]   i_ar_addr,
  input  logic [7:0]          i_ar_len,
  input  logic [2:0]          i_ar_size,
  input  logic [1:0]          i_ar_burst,
  output logic                i_r_valid,
  input  logic                i_r_ready,
  output logic [DATA_W-1:0]   i_r_data,
  output logic [1:0]          i_r_resp,
  output logic                i_r_last,
  input  logic                d_ar_valid,
  output logic                d_ar_ready,
  input  logic [ADDR_W-1:0]   d_ar_addr,
  input  logic [7:0]          d_ar_len,
  input  logic [2:0]          d_ar_size,
  input  logic [1:0]          d_ar_burst,
  output logic                d_r_valid,
  input  logic                d_r_ready,
  output logic [DATA_W-1:0]   d_r_data,
  output logic [1:0]          d_r_resp,
  output logic                d_r_last,
  input  logic                d_aw_valid,
  output logic                d_aw_ready,
  input  logic [ADDR_W-1:0]   d_aw_addr,
  input  logic [7:0]          d_aw_len,
  input  logic [2:0]          d_aw_size,
  input  logic [1:0]          d_aw_burst,
  input  logic                d_w_valid,
  output logic                d_w_ready,
  input  logic [DATA_W-1:0]   d_w_data,
  input  logic [DATA_W/8-1:0] d_w_strb,
  input  logic                d_w_last,
  output logic                d_b_valid,
  output logic [1:0]          d_b_resp,
  input  logic                d_b_ready,
  output logic                m_ar_valid,
  input  logic                m_ar_ready,
  output logic [ADDR_W-1:0]   m_ar_addr,
  output logic [7:0]          m_ar_len,
  output logic [2:0]          m_ar_size,
  output logic [1:0]          m_ar_burst,
  input  logic                m_r_valid,
  output logic                m_r_ready,
  input  logic [DATA_W-1:0]   m_r_data,
  input  logic [1:0]          m_r_resp,
  input  logic                m_r_last,
  output logic                m_aw_valid,
  input  logic                m_aw_ready,
  output logic [ADDR_W-1:0]   m_aw_addr,
  output logic [7:0]          m_aw_len,
  output logic [2:0]          m_aw_size,
  output logic [1:0]          m_aw_burst,
  output logic                m_w_valid,
  input  logic                m_w_ready,
  output logic [DATA_W-1:0]   m_w_data,
  output logic [DATA_W/8-1:0] m_w_strb,
  output logic                m_w_last,
  input  logic                m_b_valid,
  input  logic [1:0]          m_b_resp,
  output logic                m_b_ready,
  output logic                bus_err
);
  r_state_e r_state_q, r_state_d;
  w_state_e w_state_q, w_state_d;
  logic grant_q, grant_d, last_grant_q, last_grant_d, bus_err_q, bus_err_d;
  logic sel, cand_d, r_addr, r_data, w_idle, w_data, w_resp, gd, ri, rd, r_hs, b_hs;
  assign r_addr = r_state_q == R_ADDR;
  assign r_data = r_state_q == R_DATA;
  assign w_idle = w_state_q == W_IDLE;
  assign w_data = w_state_q == W_DATA;
  assign w_resp = w_state_q == W_RESP;
  assign gd = grant_q == GRANT_D;
  assign ri = r_data && !gd;
  assign rd = r_data && gd;
  // D reads wait for the write sequence to drain so they observe the store
  assign cand_d = d_ar_valid && w_idle;
  axi_arb_grant u_grant (
    .cand_i(i_ar_valid),
    .cand_d(cand_d),
    .last_grant(last_grant_q),
    .grant(sel)
  );
  assign m_ar_valid = r_addr && (gd ? d_ar_valid : i_ar_valid);
  assign m_ar_addr  = r_addr ? (gd ? d_ar_addr : i_ar_addr) : '0;
  assign m_ar_len   = r_addr ? (gd ? d_ar_len : i_ar_len) : '0;
  assign m_ar_size  = r_addr ? (gd ? d_ar_size : i_ar_size) : '0;
  assign m_ar_burst = r_addr ? (gd ? d_ar_burst : i_ar_burst) : '0;
  assign i_ar_ready = r_addr && !gd && m_ar_ready;
  assign d_ar_ready = r_addr && gd && m_ar_ready;
  assign m_r_ready  = r_data && (gd ? d_r_ready : i_r_ready);
  assign i_r_valid  = ri && m_r_valid;
  assign i_r_data   = ri ? m_r_data : '0;
  assign i_r_resp   = ri ? m_r_resp : '0;
  assign i_r_last   = ri && m_r_last;
  assign d_r_valid  = rd && m_r_valid;
  assign d_r_data   = rd ? m_r_data : '0;
  assign d_r_resp   = rd ? m_r_resp : '0;
  assign d_r_last   = rd && m_r_last;
  assign m_aw_valid = w_idle && d_aw_valid;
  assign d_aw_ready = w_idle && m_aw_ready;
  assign m_aw_addr  = w_idle ? d_aw_addr : '0;
  assign m_aw_len   = w_idle ? d_aw_len : '0;
  assign m_aw_size  = w_idle ? d_aw_size : '0;
  assign m_aw_burst = w_idle ? d_aw_burst : '0;
  assign m_w_valid  = w_data && d_w_valid;
  assign d_w_ready  = w_data && m_w_ready;
  assign m_w_data   = w_data ? d_w_data : '0;
  assign m_w_strb   = w_data ? d_w_strb : '0;
  assign m_w_last   = w_data && d_w_last;
  assign d_b_valid  = w_resp && m_b_valid;
  assign m_b_ready  = w_resp && d_b_ready;
  assign d_b_resp   = w_resp ? m_b_resp : '0;
  assign r_hs = m_r_valid && m_r_ready;
  assign b_hs = m_b_valid && m_b_ready;
  assign bus_err = bus_err_q;
  always_comb begin
    r_state_d = r_state_q;
    w_state_d = w_state_q;
    grant_d = grant_q;
    last_grant_d = last_grant_q;
    bus_err_d = bus_err_q || (r_hs && resp_err(m_r_resp)) || (b_hs && resp_err(m_b_resp));
    if (r_state_q == R_IDLE && (i_ar_valid || cand_d)) begin
      r_state_d = R_ADDR;
      grant_d = sel;
    end
    if (m_ar_valid && m_ar_ready) r_state_d = R_DATA;
    if (r_hs && m_r_last) begin
      r_state_d = R_IDLE;
      last_grant_d = grant_q;
    end
    if (m_aw_valid && m_aw_ready) w_state_d = W_DATA;
    if (m_w_valid && m_w_ready && d_w_last) w_state_d = W_RESP;
    if (b_hs) w_state_d = W_IDLE;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state_q <= R_IDLE;
      w_state_q <= W_IDLE;
      grant_q <= GRANT_I;
      last_grant_q <= GRANT_D;
      bus_err_q <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      w_state_q <= w_state_d;
      grant_q <= grant_d;
      last_grant_q <= last_grant_d;
      bus_err_q <= bus_err_d;
    end
  end
endmodule

// File: doc/axi_bus_arbiter.md
Name: axi_bus_arbiter

Overview:
- Shares the single 64-bit AXI4 memory/device port between the instruction-fetch side (I, read-only) and the load/store side (D, read+write).
- Sits between the IFU/ICache refill, the LSU/DCache refill and device path, and the SoC AXI slave.
- Arbitrates the AR/R channels with transaction-level locking.
- Tracks the AW/W/B sequence of D and orders D reads behind outstanding D writes.

Parameters:
- ADDR_W, 64, address width of all AR/AW channels.
- DATA_W, 64, data width of R/W channels; strobe width is DATA_W/8.

Ports:
- clock  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- i_ar_valid/i_ar_ready  in/out  1/1  I-side read address handshake.
- i_ar_addr, i_ar_len, i_ar_size, i_ar_burst  in  ADDR_W,8,3,2  I-side read address fields.
- i_r_valid, i_r_ready  out/in  1/1  I-side read data handshake.
- i_r_data, i_r_resp, i_r_last  out  DATA_W,2,1  I-side read data fields.
- d_ar_* / d_r_*  same set and widths as the I side  D-side read channels.
- d_aw_valid/d_aw_ready, d_aw_addr, d_aw_len, d_aw_size, d_aw_burst  in/out,in  1/1,ADDR_W,8,3,2  D write address.
- d_w_valid/d_w_ready, d_w_data, d_w_strb, d_w_last  in/out,in  1/1,DATA_W,DATA_W/8,1  D write data.
- d_b_valid, d_b_resp, d_b_ready  out,out,in  1,2,1  D write response.
- m_ar_*, m_r_*, m_aw_*, m_w_*, m_b_*  mirror of the above, opposite direction  master port to the slave.
- bus_err  out  1  sticky flag: any R or B handshake with resp != 2'b00.

Behaviour:
- Read FSM states: R_IDLE, R_ADDR, R_DATA. Registers: grant (0=I, 1=D) and last_grant.
- R_IDLE:
  - Computes candidates: i_ar_valid, and d_ar_valid only if the write FSM is in W_IDLE.
  - If any candidate is present, latch grant and go to R_ADDR; otherwise stay.
  - Fixed priority: D over I.
- R_ADDR:
  - m_ar_* = grantee's ar fields; m_ar_valid = grantee's ar_valid.
  - Grantee's ar_ready = m_ar_ready. Non-grantee ar_ready = 0.
  - On m_ar_valid && m_ar_ready, go to R_DATA.
- R_DATA:
  - m_r_* routed to the grantee; m_r_ready = grantee's r_ready. Non-grantee r_valid = 0.
  - On m_r_valid && m_r_ready && m_r_last, update last_grant = grant and go to R_IDLE.
- Outside R_ADDR: m_ar_valid = 0 and both ar_ready = 0.
- Outside R_DATA: m_r_ready = 0 and both r_valid = 0.
- Read latency overhead: exactly 1 arbitration cycle (R_IDLE to R_ADDR) before AR is presented. Back-to-back reads have one idle cycle between R last and the next AR.
- Write FSM states: W_IDLE, W_DATA, W_RESP.
  - W_IDLE: m_aw_* = d_aw_*, d_aw_ready = m_aw_ready. On AW handshake go to W_DATA.
  - W_DATA: m_w_* = d_w_*. On W handshake with d_w_last, go to W_RESP.
  - W_RESP: d_b_* = m_b_*. On B handshake go to W_IDLE.
  - AW valid/ready are forced to 0 outside W_IDLE. W valid/ready are forced to 0 outside W_DATA. B valid/ready are forced to 0 outside W_RESP.
- Ordering:
  - A D read is never granted while the write FSM is not in W_IDLE.
  - I reads are unaffected by writes and may overlap them.
  - A D read already in R_ADDR/R_DATA does not block the write FSM.
- Simultaneous events: i_ar_valid and d_ar_valid in the same R_IDLE cycle grants D (fixed priority). AR and AW may handshake in the same cycle.
- Reset values:
  - Both FSMs idle; grant = 0; last_grant = 1; bus_err = 0.
  - All m_*_valid, m_*_ready, *_ar_ready, *_r_valid, d_aw_ready, d_w_ready and d_b_valid = 0.
  - Data and address outputs are don't-care but driven to 0.
- Reset mid-transfer: FSMs return to idle the next cycle. In-flight bursts are abandoned; the slave is reset by the same reset.
- bus_err: set on any R or B handshake with resp != 0; cleared only by reset.

Optional Feature:
- Macro: AXI_ARB_ROUND_ROBIN_EN.
- Defined: when both candidates are valid in R_IDLE, grant = !last_grant. A single valid candidate is granted directly.
- Undefined: fixed D-over-I priority. last_grant is still maintained but unused.

Decomposition:
- Shared package: FSM state encodings, grant encodings (GRANT_I, GRANT_D), AXI resp constants (OKAY = 2'b00), burst INCR = 2'b01.
- One natural sub-module, axi_arb_grant: pure combinational grant select from candidates, last_grant and the macro. The top level holds both FSMs and the muxing.

Test Plan:
- Only i_ar_valid, addr 0x80000000, len 3 (4 beats): m_ar_valid rises 1 cycle after i_ar_valid; 4 beats reach i_r_*; d_r_valid stays 0; returns to R_IDLE after the last beat.
- i_ar and d_ar valid in the same cycle, fixed priority: D's address is on m_ar first. I is granted after D's R last, with one idle cycle in between.
- AXI_ARB_ROUND_ROBIN_EN, both requesting continuously for 4 transactions: grant order is I, D, I, D, starting from reset last_grant = 1.
- D store to 0xa00003f8, data 0x11, strb 0x01, with B held off 5 cycles; d_ar issued meanwhile: m_ar_valid stays 0 until the B handshake. An I read issued in that window completes normally.
- Slave returns r_resp = 2'b10 on one beat: bus_err = 1 the next cycle and stays 1 until reset.
- Reset asserted in R_DATA mid-burst: the next cycle all valid/ready outputs are 0, both FSMs are idle, and a new I read then proceeds normally.
